imem_loader: RTL
================

Name: imem_loader

Overview:
Boot-time writer for the instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It then issues one write per word into the instruction memory write port, starting at word 0. The core is held in reset until the whole program image has been written.

Parameters:
ADDR_W, 10, word-address width; memory depth = 2^ADDR_W words (1024).
LEN_W, 16, width of the word-count header field; must be > ADDR_W.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
byte_valid  input  1  host presents byte_data.
byte_data  input  8  stream byte.
byte_ready  output  1  loader can accept a byte this cycle.
mem_we  output  1  instruction-memory write enable, one cycle per word.
mem_addr  output  32  byte address, word aligned; bits [1:0] are always 0; memory indexes with [31:2].
mem_wd  output  32  assembled instruction word.
core_rst_n  output  1  active-low reset to the core; high only in DONE.
busy  output  1  high in LEN, DATA and WRITE.
done  output  1  high in DONE.
error  output  1  high in ERR.
words_written  output  LEN_W  count of words committed in the current load.

Behaviour:
- Reset (rst=1 at a clock edge): the state goes to IDLE.
  - byte_ready=0, mem_we=0, mem_addr=0, mem_wd=0, core_rst_n=0, busy=0, done=0, error=0, words_written=0.
  - Byte counter and length register are cleared.
  - rst has priority over every other input on the same edge.
- A byte is accepted only on an edge where byte_valid=1 and byte_ready=1. byte_data is sampled on that edge. byte_valid without byte_ready causes no state change.
- byte_ready=1 only in LEN and DATA. It is registered and depends on state only, not on byte_valid.
- States:
  - IDLE: on start, go to LEN, clear the byte counter and words_written, set mem_addr=0.
  - LEN: accept 2 bytes; first byte is len[7:0], second is len[15:8]. Upper bits of LEN_W beyond 16 are zero. After the 2nd accepted byte:
    - len==0: go to DONE.
    - len > 2^ADDR_W: go to ERR.
    - otherwise: go to DATA.
  - DATA: accept 4 bytes into mem_wd, little-endian: byte0 goes to [7:0], byte3 to [31:24]. On the edge that accepts byte3, go to WRITE.
  - WRITE: exactly one cycle, with mem_we=1, mem_addr and mem_wd stable. On exit:
    - mem_addr += 4 and words_written += 1.
    - If words_written (after increment) == len, go to DONE; else go to DATA.
  - DONE: core_rst_n=1, done=1. start goes to LEN (reload) and asserts core_rst_n=0 on the same edge.
  - ERR: error=1, core_rst_n=0, byte_ready=0. Only start or rst leaves ERR; start goes to LEN.
- start is ignored in LEN, DATA and WRITE.
- mem_we is never high outside WRITE. Throughput is at most one word per 5 cycles when the host streams back-to-back.
- Address wrap: cannot occur, because len ≤ 2^ADDR_W is guaranteed by the ERR check. mem_addr after the last write equals 4*len.
- Gaps: byte_valid may drop for any number of cycles mid-word or mid-header. Partial state is held indefinitely; there is no timeout.
- Reset mid-load: words already written stay in memory. Loader state and outputs return to their reset values, and core_rst_n stays 0.
- mem_wd holds its last value outside WRITE. Only WRITE cycles are meaningful.

Test Plan:
1. Reset then idle: hold rst=1 for 2 cycles, then release → all outputs 0, core_rst_n=0, byte_ready=0, state stays IDLE with no start.
2. Two-word load: start, then bytes 02 00 | 13 05 A0 00 | 93 05 B0 00, back-to-back →
   - mem_we pulses twice: addr 0x0 with data 0x00A00513, then addr 0x4 with data 0x00B00593.
   - words_written=2, done=1, core_rst_n=1.
   - byte_ready=0 during each WRITE cycle.
3. Backpressure/gaps: same image with byte_valid deasserted for 3 cycles between each byte, and byte_valid high during a WRITE cycle → identical writes; no byte consumed while byte_ready=0.
4. Zero length: start, then bytes 00 00 → DONE within 1 cycle after the 2nd byte, mem_we never asserted, core_rst_n=1.
5. Oversize: start, then bytes 01 04 (len=1025, ADDR_W=10) → error=1, byte_ready=0, no write. A subsequent start returns to LEN.
6. Reset mid-load: assert rst after the 2nd data byte of word 1 → outputs return to reset values. A new start plus a 1-word image writes to addr 0x0. A start pulse sent during DATA earlier is shown to be ignored.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory.
//
// Takes a byte stream (valid/ready) holding a 2-byte little-endian word-count header
// followed by little-endian 32-bit words. Each assembled word is written into the
// instruction memory, starting at byte address 0. The core is held in reset until the
// whole image has been written.
//
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   start          one-cycle pulse; begins a load from IDLE, DONE or ERR
//   byte_valid     host presents byte_data
//   byte_data      stream byte
//   byte_ready     loader accepts a byte this cycle (LEN and DATA only)
//   mem_we         one-cycle instruction-memory write strobe
//   mem_addr       word-aligned byte address of the write
//   mem_wd         assembled instruction word
//   core_rst_n     active-low core reset, released only in DONE
//   busy           loading (LEN, DATA, WRITE)
//   done           image fully written
//   error          header length exceeded memory depth
//   words_written  words committed in the current load
module imem_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wd,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_written
);

    typedef enum logic [2:0] {StIdle, StLen, StData, StWrite, StDone, StErr} state_e;

    // Largest image that fits in the memory.
    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(1) << ADDR_W;

    state_e           state;
    logic [1:0]       byte_cnt;
    logic [LEN_W-1:0] len;

    logic             take;
    logic [LEN_W-1:0] len_full;
    logic [LEN_W-1:0] ww_inc;

    always_comb begin
        take     = byte_valid & byte_ready;
        // Full header as it will be once the second header byte lands.
        len_full = LEN_W'({byte_data, len[7:0]});
        ww_inc   = words_written + LEN_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            byte_cnt      <= 2'd0;
            len           <= '0;
            byte_ready    <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 32'd0;
            mem_wd        <= 32'd0;
            core_rst_n    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            words_written <= '0;
        end else begin
            // Write strobe lasts exactly the one WRITE cycle.
            mem_we <= 1'b0;

            unique case (state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        state         <= StLen;
                        byte_cnt      <= 2'd0;
                        len           <= '0;
                        words_written <= '0;
                        mem_addr      <= 32'd0;
                        byte_ready    <= 1'b1;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        error         <= 1'b0;
                        core_rst_n    <= 1'b0;
                    end
                end

                StLen: begin
                    if (take) begin
                        if (byte_cnt == 2'd0) begin
                            len[7:0] <= byte_data;
                            byte_cnt <= 2'd1;
                        end else begin
                            len      <= len_full;
                            byte_cnt <= 2'd0;
                            if (len_full == '0) begin
                                state      <= StDone;
                                byte_ready <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                core_rst_n <= 1'b1;
                            end else if (len_full > MaxLen) begin
                                state      <= StErr;
                                byte_ready <= 1'b0;
                                busy       <= 1'b0;
                                error      <= 1'b1;
                            end else begin
                                state <= StData;
                            end
                        end
                    end
                end

                StData: begin
                    if (take) begin
                        unique case (byte_cnt)
                            2'd0: mem_wd[7:0]   <= byte_data;
                            2'd1: mem_wd[15:8]  <= byte_data;
                            2'd2: mem_wd[23:16] <= byte_data;
                            2'd3: mem_wd[31:24] <= byte_data;
                            default: ;
                        endcase
                        // Wraps back to 0 after the last byte of the word.
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state      <= StWrite;
                            byte_ready <= 1'b0;
                            mem_we     <= 1'b1;
                        end
                    end
                end

                StWrite: begin
                    mem_addr      <= mem_addr + 32'd4;
                    words_written <= ww_inc;
                    if (ww_inc == len) begin
                        state      <= StDone;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
                    end else begin
                        state      <= StData;
                        byte_ready <= 1'b1;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
